// File: rtl/hub75_pkg.sv
// hub75_pkg: shared scan states, panel polarities and pixel slicing helpers
package hub75_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY} scan_state_t;
  localparam logic OE_ACTIVE = 1'b0;
  localparam logic LATCH_ACTIVE = 1'b1;
  localparam int PIX_MAX = 48;
  function automatic int width_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [2:0] chan_bits(input logic [PIX_MAX-1:0] pix, input int cb, input int p);
    logic [5:0] b, g, r;
    b = 6'(p);
    g = 6'(cb + p);
    r = 6'(2 * cb + p);
    return {pix[r], pix[g], pix[b]};
  endfunction
endpackage

// File: rtl/hub75_bcm_scanner_if.sv
// hub75_bcm_scanner_if: pixel request/response bus between scanner and pixel source
interface hub75_bcm_scanner_if
  import hub75_pkg::*;
#(
  parameter int NUM_COLS = 64,
  parameter int SCAN_RATE = 32,
  parameter int COLOR_BITS = 3
);
  logic [3*COLOR_BITS-1:0] pix_data0, pix_data1;
  logic pix_valid, pix_ready;
  logic [width_of(SCAN_RATE)-1:0] pix_row;
  logic [width_of(NUM_COLS)-1:0] pix_col;
  logic [width_of(COLOR_BITS)-1:0] pix_plane;
  modport master (input pix_data0, pix_data1, pix_valid, output pix_ready, pix_row, pix_col, pix_plane);
  modport slave (output pix_data0, pix_data1, pix_valid, input pix_ready, pix_row, pix_col, pix_plane);
endinterface

// File: rtl/bcm_oe_timer.sv
// bcm_oe_timer: binary-weighted display interval, done on its final cycle
module bcm_oe_timer
  import hub75_pkg::*;
#(
  parameter int COLOR_BITS = 3,
  parameter int BASE_OE_CYCLES = 8,
  localparam int PW = width_of(COLOR_BITS),
  localparam int TW = width_of((BASE_OE_CYCLES << (COLOR_BITS - 1)) + 1)
)(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  input  logic [PW-1:0] plane,
  output logic done
);
  logic [TW-1:0] cnt;
  assign done = run && cnt == '0;
  // load the plane weight minus one, then count down while displaying
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= TW'((BASE_OE_CYCLES << plane) - 1);
    else if (run && cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/hub75_bcm_scanner.sv
// hub75_bcm_scanner: row/bit-plane scan engine driving HUB75 shift, latch and OE
module hub75_bcm_scanner
  import hub75_pkg::*;
#(
  parameter int NUM_COLS = 64,
  parameter int SCAN_RATE = 32,
  parameter int COLOR_BITS = 3,
  parameter int BASE_OE_CYCLES = 8,
  localparam int AW = width_of(SCAN_RATE),
  localparam int CW = width_of(NUM_COLS),
  localparam int PW = width_of(COLOR_BITS)
)(
  input  logic clk_in,
  input  logic rst_in_n,
  input  logic enable,
  hub75_bcm_scanner_if.master pix,
  output logic [AW-1:0] hub75_addr,
  output logic [2:0] hub75_rgb0,
  output logic [2:0] hub75_rgb1,
  output logic hub75_latch,
  output logic hub75_OE,
  output logic hub75_clk,
  output logic frame_done
);
  scan_state_t state, state_nxt;
  logic [AW-1:0] row;
  logic [CW-1:0] col;
  logic [PW-1:0] plane;
  logic ready, oe_done, last_col, last_row, last_plane;
  assign last_col = col == CW'(NUM_COLS - 1);
  assign last_row = row == AW'(SCAN_RATE - 1);
  assign last_plane = plane == PW'(COLOR_BITS - 1);
  assign pix.pix_ready = ready;
  assign pix.pix_row = row;
  assign pix.pix_col = col;
  assign pix.pix_plane = plane;
  bcm_oe_timer #(.COLOR_BITS(COLOR_BITS), .BASE_OE_CYCLES(BASE_OE_CYCLES)) u_timer (
    .clk(clk_in), .rst_n(rst_in_n), .load(state == LATCH), .run(state == DISPLAY),
    .plane(plane), .done(oe_done)
  );
  // scan state register
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) state <= IDLE;
    else state <= state_nxt;
  // next scan state; enable only matters when a frame starts
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = enable ? SHIFT_LO : IDLE;
      SHIFT_LO: state_nxt = pix.pix_valid ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: state_nxt = last_col ? BLANK : SHIFT_LO;
      BLANK:    state_nxt = LATCH;
      LATCH:    state_nxt = DISPLAY;
      DISPLAY:  state_nxt = !oe_done ? DISPLAY : (last_row && last_plane && !enable) ? IDLE : SHIFT_LO;
      default:  state_nxt = IDLE;
    endcase
  end
  // registered pins and row/col/plane counters, all decoded from the upcoming state
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      ready <= 1'b0;
      hub75_clk <= 1'b0;
      hub75_latch <= !LATCH_ACTIVE;
      hub75_OE <= !OE_ACTIVE;
      frame_done <= 1'b0;
      hub75_addr <= '0;
      hub75_rgb0 <= '0;
      hub75_rgb1 <= '0;
      row <= '0;
      col <= '0;
      plane <= '0;
    end else begin
      ready <= state_nxt == SHIFT_LO;
      hub75_clk <= state_nxt == SHIFT_HI;
      hub75_latch <= state_nxt == LATCH ? LATCH_ACTIVE : !LATCH_ACTIVE;
      hub75_OE <= state_nxt == DISPLAY ? OE_ACTIVE : !OE_ACTIVE;
      frame_done <= oe_done && last_row && last_plane;
      if (state_nxt == LATCH) hub75_addr <= row;
      if (state == SHIFT_LO && pix.pix_valid) begin
        hub75_rgb0 <= chan_bits(PIX_MAX'(pix.pix_data0), COLOR_BITS, int'(plane));
        hub75_rgb1 <= chan_bits(PIX_MAX'(pix.pix_data1), COLOR_BITS, int'(plane));
      end
      if (state == SHIFT_HI) col <= last_col ? '0 : col + 1'b1;
      if (oe_done) begin
        plane <= last_plane ? '0 : plane + 1'b1;
        if (last_plane) row <= last_row ? '0 : row + 1'b1;
      end
    end
endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// tb_hub75_bcm_scanner: scoreboard bench for shift data, latch address, plane timing and frame pulses
module tb_hub75_bcm_scanner;
  localparam int EV_SHIFT = 0, EV_LATCH = 1, EV_PLANE = 2, EV_DONE = 3;
  localparam logic [5:0] TAB0 [4] = '{6'b011011, 6'b100100, 6'b110010, 6'b001101};
  localparam logic [5:0] TAB1 [4] = '{6'b110110, 6'b001001, 6'b011100, 6'b100011};
  localparam logic [2:0] EXP_B0 [3] = '{3'b101, 3'b011, 3'b101};
  localparam logic [2:0] EXP_B1 [3] = '{3'b010, 3'b100, 3'b010};
  typedef struct {int kind; int val;} ev_t;
  ev_t exp_q[$];
  int checks = 0, errors = 0, done_cnt = 0, plen = 0, oe_cnt = 0, nb = 0;
  logic clk = 0, rst_n = 0, enable = 0, valid = 1, mon_en = 0, busy = 0, oe_prev = 1;
  logic [0:0] addr, addr_b, addr_prev = 0;
  logic [2:0] rgb0, rgb1, rgb0_b, rgb1_b;
  logic latch, oe, hclk, fdone, latch_b, oe_b, hclk_b, fdone_b;

  always #5 clk = ~clk;

  hub75_bcm_scanner_if #(.NUM_COLS(4), .SCAN_RATE(2), .COLOR_BITS(2)) bus ();
  assign bus.pix_data0 = TAB0[bus.pix_col];
  assign bus.pix_data1 = TAB1[bus.pix_col] ^ {6{bus.pix_row[0]}};
  assign bus.pix_valid = valid;
  hub75_bcm_scanner #(.NUM_COLS(4), .SCAN_RATE(2), .COLOR_BITS(2), .BASE_OE_CYCLES(2)) dut (
    .clk_in(clk), .rst_in_n(rst_n), .enable(enable), .pix(bus), .hub75_addr(addr),
    .hub75_rgb0(rgb0), .hub75_rgb1(rgb1), .hub75_latch(latch), .hub75_OE(oe),
    .hub75_clk(hclk), .frame_done(fdone)
  );

  hub75_bcm_scanner_if #(.NUM_COLS(4), .SCAN_RATE(2), .COLOR_BITS(3)) bus_b ();
  assign bus_b.pix_data0 = 9'b101_010_111;
  assign bus_b.pix_data1 = 9'b010_101_000;
  assign bus_b.pix_valid = 1'b1;
  hub75_bcm_scanner #(.NUM_COLS(4), .SCAN_RATE(2), .COLOR_BITS(3), .BASE_OE_CYCLES(2)) dut_b (
    .clk_in(clk), .rst_in_n(rst_n), .enable(1'b1), .pix(bus_b), .hub75_addr(addr_b),
    .hub75_rgb0(rgb0_b), .hub75_rgb1(rgb1_b), .hub75_latch(latch_b), .hub75_OE(oe_b),
    .hub75_clk(hclk_b), .frame_done(fdone_b)
  );

  function automatic logic [2:0] sl(input logic [5:0] px, input int b);
    logic [5:0] s;
    s = px >> b;
    return {s[4], s[2], s[0]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int val, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got unexpected event 0x%0h expected none", name, val);
    end else begin
      e = exp_q.pop_front();
      check(name, kind * 65536 + val, e.kind * 65536 + e.val);
    end
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (done_cnt < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < n) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got %0d pulses expected %0d", done_cnt, n);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    if (!oe) oe_cnt++;
    if (oe && !oe_prev) begin
      expect_ev(EV_PLANE, oe_cnt * 256 + plen, "plane_timing");
      oe_cnt = 0;
      busy = 0;
    end
    if (busy) plen++;
    else if (bus.pix_ready) begin
      busy = 1;
      plen = 1;
    end
    if (fdone) begin
      done_cnt++;
      expect_ev(EV_DONE, 0, "frame_done");
    end
    if (hclk) expect_ev(EV_SHIFT, {rgb0, rgb1}, "shift_rgb");
    if (latch) expect_ev(EV_LATCH, addr, "latch_addr");
    if (addr != addr_prev) check("addr_change_in_latch", latch, 1);
    oe_prev = oe;
    addr_prev = addr;
  end

  always @(negedge clk) if (hclk_b && nb < 24) begin
    check("slice_rgb0", rgb0_b, EXP_B0[(nb / 4) % 3]);
    check("slice_rgb1", rgb1_b, EXP_B1[(nb / 4) % 3]);
    nb++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    logic [5:0] v;
    repeat (3) @(negedge clk);
    check("rst_oe", oe, 1);
    check("rst_clk", hclk, 0);
    check("rst_latch", latch, 0);
    check("rst_ready", bus.pix_ready, 0);
    check("rst_frame_done", fdone, 0);
    check("rst_rgb", {rgb0, rgb1}, 0);
    rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      check("idle_ready", bus.pix_ready, 0);
      check("idle_oe", oe, 1);
    end
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 2; r++)
        for (int p = 0; p < 2; p++) begin
          for (int c = 0; c < 4; c++) begin
            v = TAB1[c] ^ {6{r[0]}};
            push(EV_SHIFT, {sl(TAB0[c], p), sl(v, p)});
          end
          push(EV_LATCH, r);
          push(EV_PLANE, (2 << p) * 256 + 10 + (2 << p) + ((f == 1 && r == 0 && p == 0) ? 5 : 0));
          if (r == 1 && p == 1) push(EV_DONE, 0);
        end
    mon_en = 1;
    enable = 1;
    wait_done(1);
    t = 0;
    @(negedge clk);
    while (!(bus.pix_ready && bus.pix_col == 2) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("stall_point_reached", t < 200, 1);
    enable = 0;
    valid = 0;
    repeat (5) begin
      @(negedge clk);
      check("stall_clk_low", hclk, 0);
      check("stall_rgb_frozen", {rgb0, rgb1}, {sl(TAB0[1], 0), sl(TAB1[1], 0)});
    end
    valid = 1;
    wait_done(2);
    repeat (10) begin
      @(negedge clk);
      check("post_frame_idle_ready", bus.pix_ready, 0);
      check("post_frame_idle_oe", oe, 1);
    end
    check("scoreboard_empty", exp_q.size(), 0);
    mon_en = 0;
    enable = 1;
    t = 0;
    @(negedge clk);
    while (!hclk && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("shift_hi_reached", hclk, 1);
    #2 rst_n = 0;
    #1;
    check("midrst_oe", oe, 1);
    check("midrst_clk", hclk, 0);
    check("midrst_latch", latch, 0);
    check("midrst_addr", addr, 0);
    check("midrst_ready", bus.pix_ready, 0);
    check("midrst_col", bus.pix_col, 0);
    enable = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (10) begin
      @(negedge clk);
      check("rst_idle_ready", bus.pix_ready, 0);
      check("rst_idle_oe", oe, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hub75_bcm_scanner.md
Name: hub75_bcm_scanner

Overview:
Panel-side scan engine between the column/pixel source (frame_manager side) and the HUB75 pins.
- Sequences row address and binary-code-modulation (BCM) bit planes.
- Pulls pixel pairs (upper/lower half) over a valid/ready handshake and shifts them out on led_clk.
- Generates blank/latch/OE timing so each plane is displayed for a binary-weighted time.
- Replaces the fixed hub75_addr tie-off and the free-running tvalid in the current top level.

Parameters:
NUM_COLS, 64, pixels shifted per row per plane
SCAN_RATE, 32, row addresses per frame (addr width $clog2(SCAN_RATE))
COLOR_BITS, 3, bits per channel (RGB_RES = 3*COLOR_BITS)
BASE_OE_CYCLES, 8, OE-low cycles for plane 0; plane b shows BASE_OE_CYCLES<<b

Ports:
clk_in  input  1  system clock
rst_in_n  input  1  asynchronous active-low reset
enable  input  1  run scanning; sampled only at frame start
pix_data0  input  3*COLOR_BITS  upper-half pixel {R,G,B}, R in MSBs
pix_data1  input  3*COLOR_BITS  lower-half pixel, same packing
pix_valid  input  1  pixel pair valid
pix_ready  output  1  scanner accepts pixel pair this cycle
pix_row  output  $clog2(SCAN_RATE)  row of requested pixel
pix_col  output  $clog2(NUM_COLS)  column of requested pixel
pix_plane  output  $clog2(COLOR_BITS)  current bit plane
hub75_addr  output  $clog2(SCAN_RATE)  panel row address
hub75_rgb0  output  3  upper-half bits {R,G,B}
hub75_rgb1  output  3  lower-half bits
hub75_latch  output  1  latch, active high
hub75_OE  output  1  output enable, active low
hub75_clk  output  1  shift clock
frame_done  output  1  one-cycle pulse after last row's last plane

Behaviour:
- Reset (async, rst_in_n=0): state IDLE; hub75_addr=0, rgb0=rgb1=0, latch=0, OE=1 (blanked), hub75_clk=0, pix_ready=0, pix_row/col/plane=0, frame_done=0. Reset mid-operation aborts immediately to these values.
- States: IDLE, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY.
- IDLE: OE=1. If enable=1, go to SHIFT_LO with row=0, plane=0, col=0.
- SHIFT_LO: hub75_clk=0, pix_ready=1; pix_row/col/plane show the current request.
  - On pix_valid&&pix_ready: register rgb0={R[p],G[p],B[p]} of pix_data0 and rgb1 likewise from pix_data1; go to SHIFT_HI.
  - Without valid: hold all outputs (stall of any length).
- SHIFT_HI: hub75_clk=1, pix_ready=0.
  - If col==NUM_COLS-1: go to BLANK.
  - Else col+1, back to SHIFT_LO.
- BLANK (1 cycle): OE=1, clk=0.
- LATCH (1 cycle): latch=1, OE=1, hub75_addr<=row.
- DISPLAY: OE=0 for exactly BASE_OE_CYCLES<<plane cycles, latch=0. Then OE=1 and advance:
  - plane+1, or plane=0 with row+1.
  - After row SCAN_RATE-1 / plane COLOR_BITS-1: frame_done=1 for one cycle. Go to SHIFT_LO if enable=1, else IDLE.
- enable deassert mid-frame has no effect until the frame completes.
- No overlap of shifting and display. Unstalled plane length = 2*NUM_COLS + 2 + (BASE_OE_CYCLES<<plane) cycles.
- The previous plane stays latched on the panel while shifting, but OE=1 throughout SHIFT/BLANK/LATCH.
- All outputs are registered; no combinational path from inputs to hub75_* pins.
- Counter widths: DISPLAY counter is wide enough for BASE_OE_CYCLES<<(COLOR_BITS-1).
- Row/col/plane wrap exactly at SCAN_RATE-1, NUM_COLS-1, COLOR_BITS-1 (non-power-of-two values legal).

Decomposition:
- Shared package hub75_pkg:
  - scan state enum.
  - channel-slice helper (bit p of R/G/B from a packed 3*COLOR_BITS pixel).
  - HUB75 polarity constants (OE_ACTIVE=0, LATCH_ACTIVE=1).
- One sub-module: bcm_oe_timer. Loaded with plane on entry to DISPLAY; counts BASE_OE_CYCLES<<plane; asserts done on the final cycle.

Test Plan:
All scenarios use NUM_COLS=4, SCAN_RATE=2, COLOR_BITS=2, BASE_OE_CYCLES=2 unless noted.
1. Reset: rst_in_n=0 mid-SHIFT_HI → same cycle OE=1, clk=0, latch=0, addr=0, pix_ready=0. After release with enable=0 → stays IDLE.
2. enable=1, pix_valid tied 1, pixel = col index → 4 clk rising edges, 1 BLANK, 1 latch pulse, OE low 2 cycles (plane 0) then 4 cycles (plane 1). Plane lengths exactly 12 and 14 cycles.
3. pix_data0=9'b101_010_111 (COLOR_BITS=3) at plane 1 → rgb0=3'b011 while clk rises.
4. Drop pix_valid for 5 cycles at col 2 → clk held low, outputs frozen, then resume. Exactly 4 clk edges total, plane extended by 5 cycles.
5. Full frame → hub75_addr reads 0 then 1, changing only in LATCH. frame_done pulses once after 52 cycles; frame repeats while enable=1.
6. Deassert enable during row 0 → frame finishes (frame_done pulses), then IDLE with OE=1 and no further pix_ready.
